// File: rtl/p_hardisc.sv
// Shared types and defaults for the fetch front end.
package p_hardisc;

    localparam int IFB_DEPTH_DEF = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        ualign;
        logic [1:0]  pred;
        logic        err;
    } ifb_entry_t;

endpackage

// File: rtl/ifb_ptr.sv
// Wrap-around pointer register; wraps naturally because the queue depth is a power of two.
module ifb_ptr #(
    parameter int PW = 2
) (
    input  logic          s_clk_i,
    input  logic          s_reset_i,
    input  logic          s_clear_i,
    input  logic          s_inc_i,
    output logic [PW-1:0] s_ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (s_clear_i) begin
            ptr_d = '0;
        end else if (s_inc_i) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign s_ptr_o = ptr_q;

endmodule

// File: rtl/ifb_queue.sv
// Instruction fetch buffer: small FWFT FIFO of fetch responses plus a one-cycle tap
// of the most recently accepted word for the return address stack.
module ifb_queue
    import p_hardisc::*;
#(
    parameter int DEPTH = IFB_DEPTH_DEF,
    parameter int CW    = 3
) (
    input  logic          s_clk_i,
    input  logic          s_reset_i,
    input  logic          s_flush_i,
    input  logic          s_push_i,
    input  logic [31:0]   s_data_i,
    input  logic          s_ualign_i,
    input  logic [1:0]    s_pred_i,
    input  logic          s_err_i,
    input  logic          s_pop_i,
    output logic [31:0]   s_data_o,
    output logic          s_ualign_o,
    output logic [1:0]    s_pred_o,
    output logic          s_err_o,
    output logic          s_empty_o,
    output logic          s_full_o,
    output logic          s_afull_o,
    output logic [CW-1:0] s_count_o,
    output logic          s_overflow_o,
    output logic          s_tap_valid_o,
    output logic [31:0]   s_tap_data_o,
    output logic          s_tap_ualign_o
);

    localparam int PW = CW - 1;

    ifb_entry_t    mem_q [DEPTH];
    ifb_entry_t    entry_d;
    ifb_entry_t    head;

    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          tap_valid_q, tap_valid_d;
    logic [31:0]   tap_data_q, tap_data_d;
    logic          tap_ualign_q, tap_ualign_d;

    logic          empty, full, afull;
    logic          push_acc, pop_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign afull = (count_q >= CW'(DEPTH - 1));

    // A full queue still takes a push when the head leaves in the same cycle.
    assign pop_acc  = s_pop_i & ~empty & ~s_flush_i;
    assign push_acc = s_push_i & ~s_flush_i & (~full | pop_acc);

    ifb_ptr #(.PW(PW)) u_rptr (
        .s_clk_i   (s_clk_i),
        .s_reset_i (s_reset_i),
        .s_clear_i (s_flush_i),
        .s_inc_i   (pop_acc),
        .s_ptr_o   (rptr)
    );

    ifb_ptr #(.PW(PW)) u_wptr (
        .s_clk_i   (s_clk_i),
        .s_reset_i (s_reset_i),
        .s_clear_i (s_flush_i),
        .s_inc_i   (push_acc),
        .s_ptr_o   (wptr)
    );

    always_comb begin
        entry_d = '{data: s_data_i, ualign: s_ualign_i, pred: s_pred_i, err: s_err_i};

        count_d = count_q + {{(CW-1){1'b0}}, push_acc} - {{(CW-1){1'b0}}, pop_acc};
        if (s_flush_i) begin
            count_d = '0;
        end

        overflow_d = s_flush_i ? 1'b0 : (overflow_q | (s_push_i & full & ~pop_acc));

        // The tap follows the accepted stream only; dropped or flushed words never show up.
        tap_valid_d  = push_acc;
        tap_data_d   = push_acc ? s_data_i : tap_data_q;
        tap_ualign_d = push_acc ? s_ualign_i : tap_ualign_q;
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            count_q      <= '0;
            overflow_q   <= 1'b0;
            tap_valid_q  <= 1'b0;
            tap_data_q   <= '0;
            tap_ualign_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            tap_valid_q  <= tap_valid_d;
            tap_data_q   <= tap_data_d;
            tap_ualign_q <= tap_ualign_d;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (push_acc) begin
            mem_q[wptr] <= entry_d;
        end
    end

    assign head = empty ? '0 : mem_q[rptr];

    assign s_data_o       = head.data;
    assign s_ualign_o     = head.ualign;
    assign s_pred_o       = head.pred;
    assign s_err_o        = head.err;
    assign s_empty_o      = empty;
    assign s_full_o       = full;
    assign s_afull_o      = afull;
    assign s_count_o      = count_q;
    assign s_overflow_o   = overflow_q;
    assign s_tap_valid_o  = tap_valid_q;
    assign s_tap_data_o   = tap_data_q;
    assign s_tap_ualign_o = tap_ualign_q;

endmodule

// File: tb/tb_ifb_queue.sv
// Bench for ifb_queue: directed vector table, wrap sequence and random traffic
// checked against a queue-based reference model.
module tb_ifb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          s_reset_i = 1'b0, s_flush_i = 1'b0, s_push_i = 1'b0, s_pop_i = 1'b0;
    logic [31:0]   s_data_i = '0;
    logic          s_ualign_i = 1'b0, s_err_i = 1'b0;
    logic [1:0]    s_pred_i = '0;
    logic [31:0]   s_data_o, s_tap_data_o;
    logic          s_ualign_o, s_err_o, s_empty_o, s_full_o, s_afull_o;
    logic [1:0]    s_pred_o;
    logic [CW-1:0] s_count_o;
    logic          s_overflow_o, s_tap_valid_o, s_tap_ualign_o;

    always #5 clk = ~clk;

    ifb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .s_clk_i        (clk),
        .s_reset_i      (s_reset_i),
        .s_flush_i      (s_flush_i),
        .s_push_i       (s_push_i),
        .s_data_i       (s_data_i),
        .s_ualign_i     (s_ualign_i),
        .s_pred_i       (s_pred_i),
        .s_err_i        (s_err_i),
        .s_pop_i        (s_pop_i),
        .s_data_o       (s_data_o),
        .s_ualign_o     (s_ualign_o),
        .s_pred_o       (s_pred_o),
        .s_err_o        (s_err_o),
        .s_empty_o      (s_empty_o),
        .s_full_o       (s_full_o),
        .s_afull_o      (s_afull_o),
        .s_count_o      (s_count_o),
        .s_overflow_o   (s_overflow_o),
        .s_tap_valid_o  (s_tap_valid_o),
        .s_tap_data_o   (s_tap_data_o),
        .s_tap_ualign_o (s_tap_ualign_o)
    );

    // Reference model: queue of {data, ualign, pred, err} plus sticky/tap state.
    logic [35:0] exp_q[$];
    bit          m_ovf;
    bit          m_tapv;
    logic [31:0] m_tapd;
    bit          m_tapu;

    int vec_cnt     = 0;
    int miscompares = 0;

    typedef struct {
        bit          rst, flush, push, pop;
        logic [31:0] data;
        bit          ualign;
        logic [1:0]  pred;
        bit          err;
        int          exp_count;
        bit          exp_full, exp_afull;
        logic [31:0] exp_head;
        bit          exp_tapv;
        logic [31:0] exp_tapd;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit flush, bit push, bit pop, logic [31:0] data,
                                bit u, logic [1:0] p, bit e, int cnt, bit fl, bit af,
                                logic [31:0] head, bit tapv, logic [31:0] tapd, bit ovf);
        vec_t v;
        v.rst = rst; v.flush = flush; v.push = push; v.pop = pop;
        v.data = data; v.ualign = u; v.pred = p; v.err = e;
        v.exp_count = cnt; v.exp_full = fl; v.exp_afull = af; v.exp_head = head;
        v.exp_tapv = tapv; v.exp_tapd = tapd; v.exp_ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model by the queue rules, samples 1ns after the edge.
    task automatic step(input bit rst, input bit flush, input bit push, input bit pop,
                        input logic [31:0] d, input bit u, input logic [1:0] p, input bit e);
        bit pop_acc, push_acc;
        int sz;
        s_reset_i = rst; s_flush_i = flush; s_push_i = push; s_pop_i = pop;
        s_data_i = d; s_ualign_i = u; s_pred_i = p; s_err_i = e;
        sz       = exp_q.size();
        pop_acc  = pop && (sz > 0) && !flush;
        push_acc = push && !flush && ((sz < DEPTH) || pop_acc);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_ovf = 0; m_tapv = 0; m_tapd = '0; m_tapu = 0;
        end else if (flush) begin
            exp_q.delete();
            m_ovf = 0; m_tapv = 0;
        end else begin
            if (push && sz == DEPTH && !pop_acc) m_ovf = 1;
            if (pop_acc) void'(exp_q.pop_front());
            if (push_acc) begin
                exp_q.push_back({d, u, p, e});
                m_tapd = d;
                m_tapu = u;
            end
            m_tapv = push_acc;
        end
        s_reset_i = 0; s_flush_i = 0; s_push_i = 0; s_pop_i = 0;
    endtask

    task automatic check_model(input string tag);
        int          cnt;
        logic [35:0] head;
        cnt  = exp_q.size();
        head = (cnt > 0) ? exp_q[0] : 36'h0;
        check({tag, ".count"}, 36'(s_count_o), 36'(cnt));
        check({tag, ".empty"}, 36'(s_empty_o), 36'(cnt == 0));
        check({tag, ".full"},  36'(s_full_o),  36'(cnt == DEPTH));
        check({tag, ".afull"}, 36'(s_afull_o), 36'(cnt >= DEPTH - 1));
        check({tag, ".ovf"},   36'(s_overflow_o), 36'(m_ovf));
        check({tag, ".head"},  {s_data_o, s_ualign_o, s_pred_o, s_err_o}, head);
        check({tag, ".tapv"},  36'(s_tap_valid_o), 36'(m_tapv));
        check({tag, ".tapd"},  36'(s_tap_data_o), 36'(m_tapd));
        check({tag, ".tapu"},  36'(s_tap_ualign_o), 36'(m_tapu));
    endtask

    initial begin
        vec_t        v;
        logic [31:0] val;
        bit          u;
        logic [1:0]  p;

        //            rst fl pu po data          u p     e  cnt f a head          tv tapd          ovf
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 2'd0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h00008067, 0, 2'd0, 0, 1, 0, 0, 32'h00008067, 1, 32'h00008067, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 2'd0, 0, 1, 0, 0, 32'h00008067, 0, 32'h00008067, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0, 2'd0, 0, 0, 0, 0, 32'h0,        0, 32'h00008067, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h11111111, 0, 2'd1, 0, 1, 0, 0, 32'h11111111, 1, 32'h11111111, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h22222222, 1, 2'd2, 0, 2, 0, 0, 32'h11111111, 1, 32'h22222222, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h33333333, 0, 2'd3, 1, 3, 0, 1, 32'h11111111, 1, 32'h33333333, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h44444444, 1, 2'd0, 0, 4, 1, 1, 32'h11111111, 1, 32'h44444444, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h55555555, 0, 2'd1, 0, 4, 1, 1, 32'h22222222, 1, 32'h55555555, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h66666666, 0, 2'd0, 0, 4, 1, 1, 32'h22222222, 0, 32'h55555555, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0, 2'd0, 0, 3, 0, 1, 32'h33333333, 0, 32'h55555555, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0, 2'd0, 0, 2, 0, 0, 32'h44444444, 0, 32'h55555555, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0, 2'd0, 0, 1, 0, 0, 32'h55555555, 0, 32'h55555555, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0, 2'd0, 0, 0, 0, 0, 32'h0,        0, 32'h55555555, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0, 2'd0, 0, 0, 0, 0, 32'h0,        0, 32'h55555555, 1));
        vecs.push_back(mk(0, 0, 1, 1, 32'h77777777, 0, 2'd0, 0, 1, 0, 0, 32'h77777777, 1, 32'h77777777, 1));
        vecs.push_back(mk(0, 0, 1, 0, 32'h88888888, 0, 2'd0, 0, 2, 0, 0, 32'h77777777, 1, 32'h88888888, 1));
        vecs.push_back(mk(0, 1, 1, 0, 32'h99999999, 1, 2'd3, 0, 0, 0, 0, 32'h0,        0, 32'h88888888, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'hAAAAAAAA, 1, 2'd2, 1, 1, 0, 0, 32'hAAAAAAAA, 1, 32'hAAAAAAAA, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'hBBBBBBBB, 0, 2'd1, 0, 2, 0, 0, 32'hAAAAAAAA, 1, 32'hBBBBBBBB, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'hCCCCCCCC, 1, 2'd0, 0, 3, 0, 1, 32'hAAAAAAAA, 1, 32'hCCCCCCCC, 0));
        vecs.push_back(mk(1, 0, 1, 0, 32'hDDDDDDDD, 1, 2'd3, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0));

        m_ovf = 0; m_tapv = 0; m_tapd = '0; m_tapu = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step(v.rst, v.flush, v.push, v.pop, v.data, v.ualign, v.pred, v.err);
            check($sformatf("vec%0d.count", i), 36'(s_count_o), 36'(v.exp_count));
            check($sformatf("vec%0d.empty", i), 36'(s_empty_o), 36'(v.exp_count == 0));
            check($sformatf("vec%0d.full", i),  36'(s_full_o),  36'(v.exp_full));
            check($sformatf("vec%0d.afull", i), 36'(s_afull_o), 36'(v.exp_afull));
            check($sformatf("vec%0d.head", i),  36'(s_data_o),  36'(v.exp_head));
            check($sformatf("vec%0d.tapv", i),  36'(s_tap_valid_o), 36'(v.exp_tapv));
            check($sformatf("vec%0d.tapd", i),  36'(s_tap_data_o),  36'(v.exp_tapd));
            check($sformatf("vec%0d.ovf", i),   36'(s_overflow_o),  36'(v.exp_ovf));
            check_model($sformatf("vec%0d", i));
        end

        // Alternating push/pop: five pushes walk both pointers past DEPTH-1.
        for (int i = 0; i < 10; i++) begin
            val = 32'hC0DE_0000 + 32'(i);
            u   = ((i / 2) % 2) == 1;
            p   = 2'((i / 2) % 4);
            if (i % 2 == 0) begin
                step(0, 0, 1, 0, val, u, p, 0);
                check($sformatf("wrap%0d.head", i), {4'h0, s_data_o, s_ualign_o, s_pred_o},
                      {4'h0, val, u, p});
            end else begin
                step(0, 0, 0, 1, 32'h0, 0, 2'd0, 0);
                check($sformatf("wrap%0d.count", i), 36'(s_count_o), 36'(0));
            end
            check_model($sformatf("wrap%0d", i));
        end

        // Random traffic: push-heavy first half to reach full/overflow, pop-heavy second half.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) < ((k < 300) ? 3 : 1),
                 $urandom_range(0, 3) < ((k < 300) ? 1 : 3),
                 $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
            check_model($sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
